// File: rtl/sdm_sched_pkg.sv
// Register map and field layout shared by the sigma-delta sample scheduler.
package sdm_sched_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_OSR  = 2'd1,
        REG_DATA = 2'd2,
        REG_STAT = 2'd3
    } reg_addr_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_URUN_MODE  = 1;
    localparam int CTRL_CLR_STICKY = 2;
    localparam int CTRL_FLUSH      = 3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_URUN      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 4;

endpackage

// File: rtl/sdm_sample_fifo.sv
// Synchronous sample FIFO with flush; read data is shown combinationally at the read pointer.
module sdm_sample_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = DEPTH[LVL_W-1:0];

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_LVL);
    assign pop_ok  = pop & ~flush & ~empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sdm_sample_sched.sv
// Register-programmable sample scheduler: buffers host samples and feeds the sigma-delta
// modulator one sample every OSR+1 clocks, with underrun/overflow flags and a low-water IRQ.
module sdm_sample_sched
    import sdm_sched_pkg::*;
#(
    parameter int                   DW       = 16,
    parameter int                   DEPTH    = 8,
    parameter int                   OSR_W    = 8,
    parameter int                   LOWWATER = 2,
    parameter logic signed [DW-1:0] IDLE_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_valid,
    input  logic          bus_we,
    input  logic [1:0]    bus_addr,
    input  logic [DW-1:0] bus_wdata,
    output logic [DW-1:0] bus_rdata,
    output logic          bus_ack,
    output logic [DW-1:0] din,
    output logic          sample_stb,
    output logic          irq_lw,
    output logic          irq_err
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LW_LEVEL = LVL_W'(LOWWATER);

    logic             enable;
    logic             urun_mode;
    logic [OSR_W-1:0] osr;
    logic [OSR_W-1:0] cnt;
    logic             urun;
    logic             ovf;

    reg_addr_e        addr;
    logic             acc;
    logic             wr_acc;
    logic             wr_ctrl;
    logic             flush;
    logic             clr_sticky;
    logic             push;
    logic             tick;
    logic             pop;
    logic             urun_evt;
    logic             ovf_evt;
    logic [DW-1:0]    rd_mux;
    logic             unused_wdata;

    logic [DW-1:0]    fifo_rd;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;

    // An access is taken on the edge that raises bus_ack, so its effects are visible during ack
    assign acc        = bus_valid & ~bus_ack;
    assign wr_acc     = acc & bus_we;
    assign addr       = reg_addr_e'(bus_addr);
    assign wr_ctrl    = wr_acc & (addr == REG_CTRL);
    assign flush      = wr_ctrl & bus_wdata[CTRL_FLUSH];
    assign clr_sticky = wr_ctrl & bus_wdata[CTRL_CLR_STICKY];
    assign push       = wr_acc & (addr == REG_DATA);

    assign tick     = enable & (cnt == '0);
    assign pop      = tick & ~empty & ~flush;
    assign urun_evt = tick & empty & ~flush;
    assign ovf_evt  = push & full & ~pop & ~flush;

    assign irq_err      = urun | ovf;
    assign unused_wdata = ^bus_wdata;

    sdm_sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (bus_wdata),
        .rd_data (fifo_rd),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CTRL: begin
                rd_mux[CTRL_EN]        = enable;
                rd_mux[CTRL_URUN_MODE] = urun_mode;
            end
            REG_OSR:  rd_mux[OSR_W-1:0] = osr;
            REG_DATA: rd_mux[LVL_W-1:0] = level;
            REG_STAT: begin
                rd_mux[STAT_EMPTY]               = empty;
                rd_mux[STAT_FULL]                = full;
                rd_mux[STAT_URUN]                = urun;
                rd_mux[STAT_OVF]                 = ovf;
                rd_mux[STAT_LEVEL_LSB +: LVL_W]  = level;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            enable    <= 1'b0;
            urun_mode <= 1'b0;
            osr       <= '0;
        end else begin
            bus_ack <= acc;
            if (acc && !bus_we) bus_rdata <= rd_mux;
            if (wr_ctrl) begin
                enable    <= bus_wdata[CTRL_EN];
                urun_mode <= bus_wdata[CTRL_URUN_MODE];
            end
            if (wr_acc && addr == REG_OSR) osr <= bus_wdata[OSR_W-1:0];
        end
    end

    // Sample stage: din and sample_stb are registered together off the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sample_stb <= 1'b0;
            din        <= IDLE_VAL;
            urun       <= 1'b0;
            ovf        <= 1'b0;
            irq_lw     <= 1'b0;
        end else begin
            if (!enable || cnt == '0) cnt <= osr;
            else                      cnt <= cnt - OSR_W'(1);
            sample_stb <= tick;
            if (pop)                        din <= fifo_rd;
            else if (urun_evt && urun_mode) din <= IDLE_VAL;
            // A new event in the clearing cycle keeps its sticky bit set
            urun   <= (urun & ~clr_sticky) | urun_evt;
            ovf    <= (ovf & ~clr_sticky) | ovf_evt;
            irq_lw <= enable & (level <= LW_LEVEL);
        end
    end

endmodule
